// File: rtl/bus_arbiter.sv
// Two-master system bus arbiter: picks M0 (fetch) or M1 (load/store), decodes the
// SoC address map and runs one slave transaction at a time with a timeout.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_req,
  output logic [3:0]  s_sel,
  output logic [31:0] s_addr,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_wdata,
  input  logic        s_ack,
  input  logic [31:0] s_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        win_m1;
  logic [31:0] cap_addr;
  logic        cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_sel;

  function automatic logic [3:0] addr_decode(input logic [31:0] addr);
    logic [3:0] sel;
    sel = 4'b0000;
    if (addr[31:14] == 18'h0) begin
      sel = 4'b0001;
    end else if ((addr[31:15] == 17'h0) && addr[14] && (addr[13:12] != 2'b11)) begin
      sel = 4'b0010;
    end else if (addr[31:4] == 28'h800_0000) begin
      sel = 4'b0100;
    end else if (addr[31:4] == 28'h800_0001) begin
      sel = 4'b1000;
    end else begin
      sel = 4'b0000;
    end
    return sel;
  endfunction

  // Arbitration, capture and next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;

    // last_q = 1 means M1 was granted last, so M0 wins the next contention
    if (m0_req && m1_req) begin
      win_m1 = RR_EN ? ~last_q : 1'b1;
    end else begin
      win_m1 = m1_req;
    end

    if (win_m1) begin
      cap_addr  = m1_addr;
      cap_we    = m1_we;
      cap_be    = m1_be;
      cap_wdata = m1_wdata;
    end else begin
      cap_addr  = m0_addr;
      cap_we    = 1'b0;
      cap_be    = 4'hF;
      cap_wdata = 32'h0;
    end
    cap_sel = addr_decode(cap_addr);

    case (state_q)
      IDLE: begin
        if ((m0_req || m1_req) && !rst) begin
          m0_gnt  = ~win_m1;
          m1_gnt  = win_m1;
          owner_d = win_m1;
          last_d  = win_m1;
          addr_d  = cap_addr;
          we_d    = cap_we;
          be_d    = cap_be;
          wdata_d = cap_wdata;
          sel_d   = cap_sel;
          cnt_d   = 8'd0;
          rdata_d = 32'h0;
          if ((cap_sel == 4'b0000) || (cap_sel[0] && cap_we)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // An ack in the final allowed cycle takes precedence over the timeout
        if (s_ack) begin
          rdata_d = we_q ? 32'h0 : s_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q >= CNT_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      sel_q   <= 4'h0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign s_req     = (state_q == BUSY);
  assign s_sel     = s_req ? sel_q   : 4'h0;
  assign s_addr    = s_req ? addr_q  : 32'h0;
  assign s_we      = s_req ? we_q    : 1'b0;
  assign s_be      = s_req ? be_q    : 4'h0;
  assign s_wdata   = s_req ? wdata_q : 32'h0;

  assign m0_rvalid = (state_q == RESP) && !owner_q;
  assign m1_rvalid = (state_q == RESP) && owner_q;
  assign m0_rdata  = m0_rvalid ? rdata_q : 32'h0;
  assign m1_rdata  = m1_rvalid ? rdata_q : 32'h0;
  assign m0_err    = m0_rvalid ? err_q : 1'b0;
  assign m1_err    = m1_rvalid ? err_q : 1'b0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: a reference model predicts grants and
// responses from the address map and slave plan; a monitor pops and compares on rvalid.
module tb_bus_arbiter;
  localparam int TO = 16;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          gcyc;
  } exp_t;

  typedef struct {
    int          d;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } plan_t;

  logic clk, rst;
  logic m0_req, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_rdata;
  logic m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0] m1_be;
  logic s_req, s_we, s_ack;
  logic [3:0] s_sel, s_be;
  logic [31:0] s_addr, s_wdata, s_rdata;

  logic b_m0_req, b_m0_gnt, b_m0_rvalid, b_m0_err;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic b_m1_req, b_m1_gnt, b_m1_rvalid, b_m1_err;
  logic b_s_req, b_s_we;
  logic [3:0] b_s_sel, b_s_be;
  logic [31:0] b_s_addr, b_s_wdata;

  int n_checks, n_errors, cyc, force_d;
  logic [31:0] force_rd;
  exp_t  sb[$];
  plan_t plan_q[$];

  bus_arbiter #(.TIMEOUT(TO), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_sel(s_sel), .s_addr(s_addr), .s_we(s_we), .s_be(s_be),
    .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata(s_rdata)
  );

  // Fixed-priority instance, slave acks immediately
  bus_arbiter #(.TIMEOUT(TO), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_addr(32'h0000_0040), .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid),
    .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
    .m1_req(b_m1_req), .m1_addr(32'h0000_0080), .m1_we(1'b0), .m1_be(4'hF), .m1_wdata(32'h0),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
    .s_req(b_s_req), .s_sel(b_s_sel), .s_addr(b_s_addr), .s_we(b_s_we), .s_be(b_s_be),
    .s_wdata(b_s_wdata), .s_ack(b_s_req), .s_rdata(32'h1234_5678)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] ref_sel(input logic [31:0] a);
    if (a <= 32'h0000_3FFF) return 4'b0001;
    if (a >= 32'h0000_4000 && a <= 32'h0000_6FFF) return 4'b0010;
    if (a >= 32'h8000_0000 && a <= 32'h8000_000F) return 4'b0100;
    if (a >= 32'h8000_0010 && a <= 32'h8000_001F) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic int pick_d();
    int opts[8];
    int k;
    opts = '{1, 2, 3, 4, TO - 1, TO, TO + 1, 0};
    k = opts[$urandom_range(0, 7)];
    if (k == 0) k = $urandom_range(1, 20);
    return k;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] edges[8];
    edges = '{32'h0000_3FFF, 32'h0000_4000, 32'h0000_6FFF, 32'h0000_7000,
              32'h8000_000F, 32'h8000_0010, 32'h8000_001F, 32'h8000_0020};
    case ($urandom_range(0, 6))
      0: return $urandom & 32'h0000_3FFF;
      1: return 32'h0000_4000 + $urandom_range(0, 32'h2FFF);
      2: return 32'h8000_0000 + $urandom_range(0, 15);
      3: return 32'h8000_0010 + $urandom_range(0, 15);
      4: return edges[$urandom_range(0, 7)];
      5: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference model: predicts who is granted and what the response will be
  logic last_m, w, g0, g1, e_we;
  int free_cyc;
  logic [31:0] e_addr;
  exp_t  me;
  plan_t mp;
  initial begin
    last_m = 1'b1;
    free_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_m = 1'b1;
        free_cyc = 0;
        sb.delete();
        plan_q.delete();
      end else begin
        g0 = 1'b0;
        g1 = 1'b0;
        w  = 1'b0;
        if (cyc >= free_cyc && (m0_req || m1_req)) begin
          w  = (m0_req && m1_req) ? ~last_m : m1_req;
          g0 = ~w;
          g1 = w;
        end
        chk({30'h0, m0_gnt, m1_gnt}, {30'h0, g0, g1}, "gnt{m0,m1}");
        if (g0 || g1) begin
          e_addr   = w ? m1_addr : m0_addr;
          e_we     = w ? m1_we : 1'b0;
          me.owner = w;
          me.gcyc  = cyc;
          if (ref_sel(e_addr) == 4'b0000 || (ref_sel(e_addr) == 4'b0001 && e_we)) begin
            me.err = 1'b1; me.rdata = 32'h0; me.lat = 1;
          end else begin
            mp.d     = (force_d != 0) ? force_d : pick_d();
            mp.rdata = (force_d != 0) ? force_rd : $urandom;
            mp.sel   = ref_sel(e_addr);
            mp.addr  = e_addr;
            mp.we    = e_we;
            mp.be    = w ? m1_be : 4'hF;
            mp.wdata = w ? m1_wdata : 32'h0;
            plan_q.push_back(mp);
            if (mp.d <= TO) begin
              me.err = 1'b0; me.rdata = e_we ? 32'h0 : mp.rdata; me.lat = mp.d + 1;
            end else begin
              me.err = 1'b1; me.rdata = 32'h0; me.lat = TO + 1;
            end
          end
          sb.push_back(me);
          last_m = w;
          free_cyc = cyc + me.lat + 1;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a master sees rvalid
  exp_t ce;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m0_rvalid || m1_rvalid) begin
          chk({31'h0, m0_rvalid & m1_rvalid}, 32'h0, "dual_rvalid");
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rvalid: got rvalid m0=%0b m1=%0b, expected none", m0_rvalid, m1_rvalid);
          end else begin
            ce = sb.pop_front();
            chk({31'h0, m1_rvalid}, {31'h0, ce.owner}, "rvalid_owner");
            chk(m1_rvalid ? m1_rdata : m0_rdata, ce.rdata, "rdata");
            chk({31'h0, m1_rvalid ? m1_err : m0_err}, {31'h0, ce.err}, "err");
            chk(cyc - ce.gcyc, ce.lat, "gnt_to_rvalid_latency");
            chk(m1_rvalid ? m0_rdata : m1_rdata, 32'h0, "other_rdata");
          end
        end else begin
          chk(m0_rdata | m1_rdata, 32'h0, "rdata_without_rvalid");
          chk({30'h0, m0_err, m1_err}, 32'h0, "err_without_rvalid");
        end
      end
    end
  end

  // Slave model: follows the plan pushed at grant time
  int s_k;
  bit s_act;
  plan_t sp;
  initial begin
    s_ack = 1'b0;
    s_rdata = 32'h0;
    s_act = 1'b0;
    s_k = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_act = 1'b0; s_ack = 1'b0; s_rdata = 32'h0; s_k = 0;
      end else begin
        if (s_ack) begin
          s_ack = 1'b0;
          s_rdata = 32'h0;
        end
        if (s_req) begin
          if (!s_act) begin
            if (plan_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_s_req: got s_req=1 addr %0h, expected s_req=0", s_addr);
            end else begin
              sp = plan_q.pop_front();
              s_act = 1'b1;
              s_k = 0;
            end
          end
          if (s_act) begin
            s_k++;
            chk({28'h0, s_sel}, {28'h0, sp.sel}, "s_sel");
            chk(s_addr, sp.addr, "s_addr");
            chk({27'h0, s_we, s_be}, {27'h0, sp.we, sp.be}, "s_we_be");
            chk(s_wdata, sp.wdata, "s_wdata");
            if (s_k == sp.d) begin
              s_ack = 1'b1;
              s_rdata = sp.rdata;
            end
          end
        end else if (s_act) begin
          chk(s_k, (sp.d < TO) ? sp.d : TO, "s_req_cycles");
          s_act = 1'b0;
        end
      end
    end
  end

  task automatic m0_txn(input logic [31:0] a);
    bit got;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = a;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m0_gnt) begin got = 1'b1; break; end
    end
    if (!got) chk(32'h0, 32'h1, "m0_gnt_timeout");
    @(posedge clk); #1;
    m0_req = 1'b0; m0_addr = $urandom;
  endtask

  task automatic m1_txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd);
    bit got;
    @(posedge clk); #1;
    m1_req = 1'b1; m1_addr = a; m1_we = we; m1_be = be; m1_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m1_gnt) begin got = 1'b1; break; end
    end
    if (!got) chk(32'h0, 32'h1, "m1_gnt_timeout");
    @(posedge clk); #1;
    m1_req = 1'b0; m1_addr = $urandom; m1_we = $urandom; m1_be = $urandom; m1_wdata = $urandom;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && plan_q.size() == 0 && !s_req) begin done = 1'b1; break; end
    end
    chk({31'h0, done}, 32'h1, "drain");
  endtask

  int b_grants;
  initial begin
    n_checks = 0; n_errors = 0; force_d = 0; force_rd = 32'h0;
    rst = 1'b1;
    m0_req = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b0; m1_addr = 32'h0; m1_we = 1'b0; m1_be = 4'h0; m1_wdata = 32'h0;
    b_m0_req = 1'b0; b_m1_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({28'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 32'h0, "reset_master_outputs");
    chk({27'h0, s_req, s_sel}, 32'h0, "reset_slave_outputs");
    @(posedge clk); #1 rst = 1'b0;

    // Directed: delayed IMEM read, GPIO write, unmapped, IMEM write, timeout, late ack
    force_d = 3; force_rd = 32'hDEAD_BEEF;
    m0_txn(32'h0000_0100);
    force_d = 1;
    m1_txn(32'h8000_0014, 1'b1, 4'b0011, 32'h0000_00A5);
    m1_txn(32'h0000_7000, 1'b0, 4'hF, 32'h0);
    m1_txn(32'h0000_0010, 1'b1, 4'hF, 32'h1111_2222);
    force_d = TO + 4;
    m1_txn(32'h0000_4000, 1'b0, 4'hF, 32'h0);
    force_d = TO; force_rd = 32'hCAFE_F00D;
    m1_txn(32'h0000_4000, 1'b0, 4'hF, 32'h0);
    force_d = 0;
    drain();

    // Randomized traffic, contention-heavy
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0: fork
             m0_txn(pick_addr());
             m1_txn(pick_addr(), 1'($urandom), 4'($urandom), $urandom);
           join
        1: m0_txn(pick_addr());
        default: m1_txn(pick_addr(), 1'($urandom), 4'($urandom), $urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();

    // Reset during BUSY aborts the transaction with no response
    force_d = 40;
    m1_txn(32'h0000_4000, 1'b0, 4'hF, 32'h0);
    force_d = 0;
    @(negedge clk);
    chk({31'h0, s_req}, 32'h1, "busy_before_reset");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({22'h0, m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, s_req, s_we, s_be[1:0]},
        32'h0, "outputs_after_reset");
    chk(m0_rdata | m1_rdata | s_addr | s_wdata | {24'h0, s_sel, s_be}, 32'h0, "buses_after_reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (TO + 4) @(posedge clk);
    fork
      m0_txn(32'h0000_0200);
      m1_txn(32'h0000_4100, 1'b0, 4'hF, 32'h0);
    join
    drain();

    // Fixed priority instance: M1 wins every contention
    b_grants = 0;
    @(posedge clk); #1;
    b_m0_req = 1'b1; b_m1_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk({31'h0, b_m0_gnt | b_m0_rvalid | b_m0_err}, 32'h0, "fp_m0_activity");
      if (b_m1_gnt) b_grants++;
      if (b_m1_rvalid) begin
        chk({31'h0, b_m1_err}, 32'h0, "fp_m1_err");
        chk(b_m1_rdata, 32'h1234_5678, "fp_m1_rdata");
      end else begin
        chk(b_m1_rdata | b_m0_rdata, 32'h0, "fp_rdata_idle");
      end
      if (b_s_req) begin
        chk({23'h0, b_s_sel, b_s_we, b_s_be}, {23'h0, 4'b0001, 1'b0, 4'hF}, "fp_s_ctrl");
        chk(b_s_addr | b_s_wdata, 32'h0000_0080, "fp_s_addr");
      end
    end
    b_m0_req = 1'b0; b_m1_req = 1'b0;
    chk(b_grants, 10, "fp_m1_grant_count");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
